alu_registered: RTL and testbench



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_if.sv | 22 ++
 rtl/alu_core.sv | 98 +++++++++
 rtl/alu_registered.sv | 91 +++++++++
 tb/tb_alu_registered.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the ALU and the control unit that drives it.
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_DEC  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_ROL  = 4'hB;
  localparam logic [3:0] OP_ROR  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_NEG   = 3;
  localparam int FLG_LT    = 4;
  localparam int NUM_FLAGS = 5;

  localparam int OPCODE_W = 4;

endpackage

// File: rtl/alu_if.sv
// Opcode/operand request and result/flag response between the control unit and the ALU.
interface alu_if #(parameter int WIDTH = 4);
  import alu_pkg::*;

  logic [OPCODE_W-1:0]  iOpCode;
  logic [WIDTH-1:0]     iDato_1;
  logic [WIDTH-1:0]     iDato_2;
  logic [WIDTH-1:0]     oResultado;
  logic [NUM_FLAGS-1:0] oFlags;
  logic                 oValid;

  modport master (
    output iOpCode, iDato_1, iDato_2,
    input  oResultado, oFlags, oValid
  );

  modport slave (
    input  iOpCode, iDato_1, iDato_2,
    output oResultado, oFlags, oValid
  );

endinterface

// File: rtl/alu_core.sv
// Combinational opcode decode and datapath; o_hold marks ops whose result must not be stored.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OPCODE_W-1:0]  i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [WIDTH-1:0]     o_res,
  output logic [NUM_FLAGS-1:0] o_flags,
  output logic                 o_hold
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_lt;
  logic             w_hold;
  logic             w_rsv;

  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_lt    = 1'b0;
    w_hold  = 1'b0;
    w_rsv   = 1'b0;
    case (i_op)
      OP_PASS: w_res = i_a;
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_NOT:  w_res = ~i_a;
      OP_ADD: begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        // bit WIDTH of the extended difference is the unsigned borrow
        w_sum  = {1'b0, i_a} - {1'b0, i_b};
        w_res  = w_sum[MSB:0];
        w_lt   = w_sum[WIDTH];
        w_ovf  = (i_a[MSB] != i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
        w_hold = (i_op == OP_CMP);
      end
      OP_INC: begin
        w_sum   = {1'b0, i_a} + ONE;
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = !i_a[MSB] && w_sum[MSB];
      end
      OP_DEC: begin
        w_sum = {1'b0, i_a} - ONE;
        w_res = w_sum[MSB:0];
        w_lt  = w_sum[WIDTH];
        w_ovf = i_a[MSB] && !w_sum[MSB];
      end
      OP_SHL: begin
        w_res   = {i_a[MSB-1:0], 1'b0};
        w_carry = i_a[MSB];
      end
      OP_SHR: begin
        w_res   = {1'b0, i_a[MSB:1]};
        w_carry = i_a[0];
      end
      OP_ROL: begin
        w_res   = {i_a[MSB-1:0], i_a[MSB]};
        w_carry = i_a[MSB];
      end
      OP_ROR: begin
        w_res   = {i_a[0], i_a[MSB:1]};
        w_carry = i_a[0];
      end
      default: w_rsv = 1'b1;
    endcase
  end

  always_comb begin
    o_flags            = '0;
    o_flags[FLG_ZERO]  = !w_rsv && (w_res == '0);
    o_flags[FLG_CARRY] = w_carry;
    o_flags[FLG_OVF]   = w_ovf;
    o_flags[FLG_NEG]   = w_res[MSB];
    o_flags[FLG_LT]    = w_lt;
  end

  assign o_res  = w_res;
  assign o_hold = w_hold;

endmodule

// File: rtl/alu_registered.sv
// Registered ALU: 1- or 2-stage pipeline around alu_core with CMP result hold and input-match valid.
module alu_registered
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  localparam int TW = OPCODE_W + 2 * WIDTH;

  logic [TW-1:0]        w_cur;
  logic [TW-1:0]        r_trip1;
  logic                 r_v1;
  logic [OPCODE_W-1:0]  w_core_op;
  logic [WIDTH-1:0]     w_core_a;
  logic [WIDTH-1:0]     w_core_b;
  logic [WIDTH-1:0]     w_res;
  logic [NUM_FLAGS-1:0] w_flags;
  logic                 w_hold;
  logic [WIDTH-1:0]     r_res;
  logic [NUM_FLAGS-1:0] r_flags;
  logic                 w_valid;

  assign w_cur = {bus.iOpCode, bus.iDato_1, bus.iDato_2};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trip1 <= '0;
      r_v1    <= 1'b0;
    end else begin
      r_trip1 <= w_cur;
      r_v1    <= 1'b1;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (w_core_op),
    .i_a     (w_core_a),
    .i_b     (w_core_b),
    .o_res   (w_res),
    .o_flags (w_flags),
    .o_hold  (w_hold)
  );

  if (LATENCY == 1) begin : g_lat1
    assign {w_core_op, w_core_a, w_core_b} = w_cur;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_res   <= '0;
        r_flags <= '0;
      end else begin
        if (!w_hold) r_res <= w_res;
        r_flags <= w_flags;
      end
    end

    assign w_valid = r_v1 && (r_trip1 == w_cur);
  end else begin : g_lat2
    logic [TW-1:0] r_trip2;
    logic          r_v2;

    assign {w_core_op, w_core_a, w_core_b} = r_trip1;

    // stage 2 only loads real captures, so the cleared stage 1 never leaks out after reset
    always_ff @(posedge clk) begin
      if (rst) begin
        r_trip2 <= '0;
        r_v2    <= 1'b0;
        r_res   <= '0;
        r_flags <= '0;
      end else if (r_v1) begin
        r_trip2 <= r_trip1;
        r_v2    <= 1'b1;
        if (!w_hold) r_res <= w_res;
        r_flags <= w_flags;
      end
    end

    assign w_valid = r_v1 && r_v2 && (r_trip1 == w_cur) && (r_trip2 == w_cur);
  end

  assign bus.oResultado = r_res;
  assign bus.oFlags     = r_flags;
  assign bus.oValid     = w_valid;

endmodule

// File: tb/tb_alu_registered.sv
// Bench for alu_registered: LATENCY=1 and LATENCY=2 instances driven in lockstep against an integer model.
module tb_alu_registered;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_if #(.WIDTH(4)) bus1 ();
  alu_if #(.WIDTH(4)) bus2 ();

  alu_registered #(.WIDTH(4), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(bus1));
  alu_registered #(.WIDTH(4), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // reference state: expected outputs per instance, pending capture for the 2-deep pipe, input stability
  int e1r, e1f, e2r, e2f;
  int pop, pa, pb;
  bit pv;
  int stable;
  bit have_last;
  int last_op, last_a, last_b;
  int cur_op, cur_a, cur_b;

  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output int f, output bit h);
    int sa, sb, sv, s;
    bit z, c, v, n, lt, rsv;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c = 0; v = 0; lt = 0; rsv = 0; h = 0; r = 0;
    case (op)
      0: r = a;
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4: r = 15 - a;
      5: begin s = a + b; r = s % 16; c = (s > 15); sv = sa + sb; v = (sv > 7) || (sv < -8); end
      6, 13: begin
        r = (a - b + 16) % 16; lt = (a < b); sv = sa - sb; v = (sv > 7) || (sv < -8); h = (op == 13);
      end
      7: begin s = a + 1; r = s % 16; c = (s > 15); v = (sa + 1 > 7); end
      8: begin r = (a + 15) % 16; lt = (a == 0); v = (sa - 1 < -8); end
      9: begin r = (a * 2) % 16; c = (a >= 8); end
      10: begin r = a / 2; c = (a % 2) == 1; end
      11: begin r = (a * 2) % 16 + a / 8; c = (a >= 8); end
      12: begin r = a / 2 + (a % 2) * 8; c = (a % 2) == 1; end
      default: rsv = 1;
    endcase
    z = !rsv && (r == 0);
    n = (r >= 8);
    f = int'(z) + 2 * int'(c) + 4 * int'(v) + 8 * int'(n) + 16 * int'(lt);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input int exp);
    n_total++;
    assert (obs === 8'(exp)) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, 8'(exp));
    end
  endtask

  function automatic bit exp_valid(input int lat);
    return have_last && (cur_op == last_op) && (cur_a == last_a) && (cur_b == last_b) && (stable >= lat);
  endfunction

  task automatic check_valid();
    check("valid_l1", 8'(bus1.oValid), int'(exp_valid(1)));
    check("valid_l2", 8'(bus2.oValid), int'(exp_valid(2)));
  endtask

  task automatic set_in(input bit r, input int op, input int a, input int b);
    rst = r;
    cur_op = op; cur_a = a; cur_b = b;
    bus1.iOpCode = 4'(op); bus1.iDato_1 = 4'(a); bus1.iDato_2 = 4'(b);
    bus2.iOpCode = 4'(op); bus2.iDato_1 = 4'(a); bus2.iDato_2 = 4'(b);
    #1;
    check_valid();
  endtask

  task automatic tick();
    int r, f;
    bit h;
    @(posedge clk);
    if (rst) begin
      e1r = 0; e1f = 0; e2r = 0; e2f = 0;
      pv = 0; stable = 0; have_last = 0;
    end else begin
      ref_alu(cur_op, cur_a, cur_b, r, f, h);
      if (!h) e1r = r;
      e1f = f;
      if (pv) begin
        ref_alu(pop, pa, pb, r, f, h);
        if (!h) e2r = r;
        e2f = f;
      end
      pop = cur_op; pa = cur_a; pb = cur_b; pv = 1;
      if (have_last && cur_op == last_op && cur_a == last_a && cur_b == last_b) stable++;
      else stable = 1;
      last_op = cur_op; last_a = cur_a; last_b = cur_b; have_last = 1;
    end
    #1;
    check("res_l1", 8'(bus1.oResultado), e1r);
    check("flg_l1", 8'(bus1.oFlags), e1f);
    check("res_l2", 8'(bus2.oResultado), e2r);
    check("flg_l2", 8'(bus2.oFlags), e2f);
    check_valid();
  endtask

  task automatic step(input int op, input int a, input int b, input int n);
    set_in(0, op, a, b);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_both(input string tag, input int res, input int flg);
    check({tag, "_res1"}, 8'(bus1.oResultado), res);
    check({tag, "_flg1"}, 8'(bus1.oFlags), flg);
    check({tag, "_res2"}, 8'(bus2.oResultado), res);
    check({tag, "_flg2"}, 8'(bus2.oFlags), flg);
  endtask

  initial begin
    e1r = 0; e1f = 0; e2r = 0; e2f = 0; pv = 0; stable = 0; have_last = 0;
    pop = 0; pa = 0; pb = 0; last_op = 0; last_a = 0; last_b = 0;

    set_in(1, 6, 9, 9);
    tick();
    expect_both("reset", 0, 0);
    check("reset_v1", 8'(bus1.oValid), 0);
    tick();
    set_in(0, 6, 9, 9);
    tick();
    check("sub_eq_res", 8'(bus1.oResultado), 0);
    check("sub_eq_flg", 8'(bus1.oFlags), 5'b00001);
    check("sub_eq_v1", 8'(bus1.oValid), 1);
    check("sub_eq_v2_early", 8'(bus2.oValid), 0);
    tick();
    check("sub_eq_v2", 8'(bus2.oValid), 1);

    step(5, 15, 1, 2); expect_both("add_wrap", 0, 5'b00011);
    step(5, 7, 1, 2);  expect_both("add_ovf", 8, 5'b01100);
    step(6, 3, 9, 2);  expect_both("sub_borrow", 10, 5'b11100);
    step(0, 5, 0, 2);  expect_both("pass", 5, 5'b00000);
    step(13, 3, 9, 2); expect_both("cmp_hold", 5, 5'b11100);
    step(9, 9, 0, 2);  expect_both("shl", 2, 5'b00010);
    step(12, 1, 0, 2); expect_both("ror", 8, 5'b01010);
    step(15, 5, 3, 2); expect_both("rsv", 0, 5'b00000);
    step(8, 0, 0, 2);  expect_both("dec_zero", 15, 5'b11000);

    // operand A changes every cycle, then holds
    step(5, 1, 2, 1);
    step(5, 2, 2, 1);
    step(5, 3, 2, 1);
    check("chg_v2_1", 8'(bus2.oValid), 0);
    tick();
    check("chg_v2_2", 8'(bus2.oValid), 1);
    check("chg_res2", 8'(bus2.oResultado), 5);

    // reset pulse between two ops
    step(5, 2, 3, 2);
    set_in(1, 5, 2, 3);
    tick();
    expect_both("midrst", 0, 0);
    set_in(0, 6, 7, 2);
    tick();
    check("post_rst_v2", 8'(bus2.oValid), 0);
    check("post_rst_res2", 8'(bus2.oResultado), 0);
    tick();
    check("post_rst_v2b", 8'(bus2.oValid), 1);
    check("post_rst_res2b", 8'(bus2.oResultado), 5);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        set_in(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        tick();
      end else begin
        step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(1, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
